sa_operand_streamer: RTL and testbench

- Transmit-side feeder for the systolic array: for each tile command it reads K operand beats from an A buffer (one row vector per beat) and a B buffer (one column vector per beat).
- Drives them onto the array's row_data_in and col_data_in valid/ready streams.
- Tags the first row beat with rst_accumulator_rdy and the last row beat with stream_out_rdy.
- Sits between the local operand SRAMs and the array's input ports.

---
 rtl/sa_operand_streamer_pkg.sv | 16 +
 rtl/sa_operand_streamer_stream_fifo.sv | 57 +++++
 rtl/sa_operand_streamer.sv | 201 ++++++++++++++++++++
 tb/tb_sa_operand_streamer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_operand_streamer_pkg.sv
// Shared constants for the systolic-array operand streamer: FSM encodings,
// output FIFO depth, operand buffer read latency and a FIFO pointer helper.
package sa_pkg;

    localparam int STREAM_FIFO_DEPTH = 3;
    localparam int RD_LAT            = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] p);
        return (p == 2'(STREAM_FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/sa_operand_streamer_stream_fifo.sv
// Three-entry output FIFO for one operand stream; head is presented
// combinationally and occupancy is exported for issue throttling.
module sa_stream_fifo
    import sa_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_data,
    output logic [1:0]   occ
);

    logic [STREAM_FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [1:0] wp_q, wp_d, rp_q, rp_d, occ_q, occ_d;
    logic push, pop;

    always_comb begin
        pop   = (occ_q != 2'd0) && rd_rdy;
        // Pushing into a full FIFO is only legal when the head leaves this cycle.
        push  = wr_en && ((occ_q != 2'(STREAM_FIFO_DEPTH)) || pop);
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push) begin
            mem_d[wp_q] = wr_data;
            wp_d        = fifo_ptr_inc(wp_q);
        end
        if (pop) begin
            rp_d = fifo_ptr_inc(rp_q);
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            wp_q  <= 2'd0;
            rp_q  <= 2'd0;
            occ_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    assign rd_vld  = (occ_q != 2'd0);
    assign rd_data = mem_q[rp_q];
    assign occ     = occ_q;

endmodule

// File: rtl/sa_operand_streamer.sv
// Feeds A row vectors and B column vectors from the operand buffers into the
// systolic array. Optional perf counters under SA_STREAM_PERF_EN.
module sa_operand_streamer
    import sa_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int ADDR_W   = 10,
    parameter int KCNT_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KCNT_W-1:0]        tile_k,
    input  logic [ADDR_W-1:0]        a_base,
    input  logic [ADDR_W-1:0]        b_base,
    output logic                     busy,
    output logic                     done,
    output logic                     err_zero_k,
    output logic                     a_rd_en,
    output logic [ADDR_W-1:0]        a_rd_addr,
    input  logic [IN_WIDTH*ROWS-1:0] a_rd_data,
    output logic                     b_rd_en,
    output logic [ADDR_W-1:0]        b_rd_addr,
    input  logic [IN_WIDTH*COLS-1:0] b_rd_data,
    output logic [IN_WIDTH*ROWS-1:0] row_data_in,
    output logic                     row_data_in_vld,
    input  logic                     row_data_in_rdy,
    output logic                     rst_accumulator_rdy,
    output logic                     stream_out_rdy,
    output logic [IN_WIDTH*COLS-1:0] col_data_in,
    output logic                     col_data_in_vld,
`ifdef SA_STREAM_PERF_EN
    output logic [31:0]              perf_tile_cycles,
    output logic [31:0]              perf_row_stall,
    output logic [31:0]              perf_col_stall,
`endif
    input  logic                     col_data_in_rdy
);

    localparam int AW = IN_WIDTH * ROWS;
    localparam int BW = IN_WIDTH * COLS;

    logic [1:0]        state_q, state_d;
    logic [KCNT_W-1:0] tile_k_q, tile_k_d, kc_q, kc_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
    logic              err_q, err_d, zk_done_q, zk_done_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d, first_q, first_d, last_q, last_d;
    logic [1:0]        row_occ, col_occ;
    logic [AW+1:0]     row_head;
    logic [2:0]        inflight;
    logic              accept, issue, kc_last, drained;

    always_comb begin
        accept   = start && (state_q == ST_IDLE);
        kc_last  = (kc_q == tile_k_q - KCNT_W'(1));
        inflight = 3'($countones(rd_vld_q));
        // Reads in flight already own a FIFO slot, so count them against depth.
        issue    = (state_q == ST_ISSUE)
                && (({1'b0, row_occ} + inflight) < 3'(STREAM_FIFO_DEPTH))
                && (({1'b0, col_occ} + inflight) < 3'(STREAM_FIFO_DEPTH));
        drained  = (row_occ == 2'd0) && (col_occ == 2'd0) && (inflight == 3'd0);

        state_d   = state_q;
        tile_k_d  = tile_k_q;
        kc_d      = kc_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        err_d     = err_q;
        zk_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (tile_k != '0) begin
                        tile_k_d = tile_k;
                        a_base_d = a_base;
                        b_base_d = b_base;
                        kc_d     = '0;
                        err_d    = 1'b0;
                        state_d  = ST_ISSUE;
                    end else begin
                        err_d     = 1'b1;
                        zk_done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    kc_d = kc_q + KCNT_W'(1);
                    if (kc_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Beat flags travel alongside the read so they land with their data.
        rd_vld_d = RD_LAT'({rd_vld_q, issue});
        first_d  = RD_LAT'({first_q, issue && (kc_q == '0)});
        last_d   = RD_LAT'({last_q, issue && kc_last});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tile_k_q  <= '0;
            kc_q      <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            err_q     <= 1'b0;
            zk_done_q <= 1'b0;
            rd_vld_q  <= '0;
            first_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            tile_k_q  <= tile_k_d;
            kc_q      <= kc_d;
            a_base_q  <= a_base_d;
            b_base_q  <= b_base_d;
            err_q     <= err_d;
            zk_done_q <= zk_done_d;
            rd_vld_q  <= rd_vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
        end
    end

    sa_stream_fifo #(.W(AW + 2)) u_row_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rd_vld_q[RD_LAT-1]),
        .wr_data ({last_q[RD_LAT-1], first_q[RD_LAT-1], a_rd_data}),
        .rd_rdy  (row_data_in_rdy),
        .rd_vld  (row_data_in_vld),
        .rd_data (row_head),
        .occ     (row_occ)
    );

    sa_stream_fifo #(.W(BW)) u_col_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rd_vld_q[RD_LAT-1]),
        .wr_data (b_rd_data),
        .rd_rdy  (col_data_in_rdy),
        .rd_vld  (col_data_in_vld),
        .rd_data (col_data_in),
        .occ     (col_occ)
    );

    assign row_data_in         = row_head[AW-1:0];
    assign rst_accumulator_rdy = row_data_in_vld && row_head[AW];
    assign stream_out_rdy      = row_data_in_vld && row_head[AW+1];

    assign busy       = (state_q != ST_IDLE);
    assign done       = ((state_q == ST_DRAIN) && drained) || zk_done_q;
    assign err_zero_k = err_q;
    assign a_rd_en    = issue;
    assign b_rd_en    = issue;
    assign a_rd_addr  = a_base_q + ADDR_W'(kc_q);
    assign b_rd_addr  = b_base_q + ADDR_W'(kc_q);

`ifdef SA_STREAM_PERF_EN
    logic [31:0] ptc_q, ptc_d, prs_q, prs_d, pcs_q, pcs_d;

    always_comb begin
        ptc_d = ptc_q;
        prs_d = prs_q;
        pcs_d = pcs_q;
        if (accept && (tile_k != '0)) begin
            ptc_d = '0;
            prs_d = '0;
            pcs_d = '0;
        end else begin
            if (busy) ptc_d = ptc_q + 32'd1;
            if (row_data_in_vld && !row_data_in_rdy) prs_d = prs_q + 32'd1;
            if (col_data_in_vld && !col_data_in_rdy) pcs_d = pcs_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptc_q <= '0;
            prs_q <= '0;
            pcs_q <= '0;
        end else begin
            ptc_q <= ptc_d;
            prs_q <= prs_d;
            pcs_q <= pcs_d;
        end
    end

    assign perf_tile_cycles = ptc_q;
    assign perf_row_stall   = prs_q;
    assign perf_col_stall   = pcs_q;
`endif

endmodule

// File: tb/tb_sa_operand_streamer.sv
// Scoreboard bench for sa_operand_streamer: stimulus pushes expected reads and
// beats into queues, a negedge monitor pops and compares them.
module tb_sa_operand_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  tile_k = '0, a_base = '0, b_base = '0;
    logic        busy, done, err_zero_k;
    logic        a_rd_en, b_rd_en;
    logic [9:0]  a_rd_addr, b_rd_addr;
    logic [31:0] a_rd_data = '0, b_rd_data = '0;
    logic [31:0] row_data_in, col_data_in;
    logic        row_data_in_vld, col_data_in_vld;
    logic        row_data_in_rdy = 1'b1, col_data_in_rdy = 1'b1;
    logic        rst_accumulator_rdy, stream_out_rdy;

    always #5 clk = ~clk;

    sa_operand_streamer dut (
        .clk(clk), .rst(rst), .start(start), .tile_k(tile_k),
        .a_base(a_base), .b_base(b_base), .busy(busy), .done(done),
        .err_zero_k(err_zero_k), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .b_rd_data(b_rd_data), .row_data_in(row_data_in),
        .row_data_in_vld(row_data_in_vld), .row_data_in_rdy(row_data_in_rdy),
        .rst_accumulator_rdy(rst_accumulator_rdy), .stream_out_rdy(stream_out_rdy),
        .col_data_in(col_data_in), .col_data_in_vld(col_data_in_vld),
        .col_data_in_rdy(col_data_in_rdy)
    );

    int checks = 0, errors = 0;
    logic [33:0] row_q[$];
    logic [31:0] col_q[$];
    logic [19:0] addr_q[$];
    logic [9:0]  a_log[$];
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = -1;
    int row_acc = 0, col_acc = 0, first_acc_cyc = -1, last_acc_cyc = -1;
    int rd_cnt = 0, first_rd_cyc = -1, last_rd_cyc = -1;
    bit row_tog = 1'b0;

    function automatic logic [31:0] a_word(input logic [9:0] a);
        return {12'hA00, a, ~a};
    endfunction
    function automatic logic [31:0] b_word(input logic [9:0] a);
        return {12'hB00, ~a, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operand SRAM model, one cycle read latency.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_word(a_rd_addr);
        if (b_rd_en) b_rd_data <= b_word(b_rd_addr);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            row_data_in_rdy = row_tog ? ~row_data_in_rdy : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            cyc++;
            if (a_rd_en || b_rd_en) begin
                chk("rd_en_pair", 64'({a_rd_en, b_rd_en}), 64'(2'b11));
                chk("read_expected", 64'(addr_q.size() != 0), 64'(1));
                if (addr_q.size() != 0)
                    chk("rd_addr", 64'({a_rd_addr, b_rd_addr}), 64'(addr_q.pop_front()));
                a_log.push_back(a_rd_addr);
                if (rd_cnt == 0) first_rd_cyc = cyc;
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (row_data_in_vld) begin
                chk("row_expected", 64'(row_q.size() != 0), 64'(1));
                if (row_q.size() != 0) begin
                    chk("row_beat", 64'({stream_out_rdy, rst_accumulator_rdy, row_data_in}),
                        64'(row_q[0]));
                    if (row_data_in_rdy) begin
                        void'(row_q.pop_front());
                        if (row_acc == 0) first_acc_cyc = cyc;
                        row_acc++;
                        last_acc_cyc = cyc;
                    end
                end
            end else begin
                chk("row_flags_idle", 64'({stream_out_rdy, rst_accumulator_rdy}), 64'(0));
            end
            if (col_data_in_vld) begin
                chk("col_expected", 64'(col_q.size() != 0), 64'(1));
                if (col_q.size() != 0) begin
                    chk("col_beat", 64'(col_data_in), 64'(col_q[0]));
                    if (col_data_in_rdy) begin
                        void'(col_q.pop_front());
                        col_acc++;
                        last_acc_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_all_beats", 64'(row_q.size() + col_q.size()), 64'(0));
            end
        end
    end

    task automatic pulse_start(input int k, input int ab, input int bb);
        @(posedge clk); #1;
        start_cyc = cyc + 1;
        start = 1'b1; tile_k = 10'(k); a_base = 10'(ab); b_base = 10'(bb);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; row_acc = 0; col_acc = 0;
        first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
        first_rd_cyc = -1; last_rd_cyc = -1;
    endtask

    task automatic run_tile(input int k, input int ab, input int bb);
        logic [9:0] aa, ba;
        clear_stats();
        for (int i = 0; i < k; i++) begin
            aa = 10'(ab + i);
            ba = 10'(bb + i);
            addr_q.push_back({aa, ba});
            row_q.push_back({(i == k - 1), (i == 0), a_word(aa)});
            col_q.push_back(b_word(ba));
        end
        pulse_start(k, ab, bb);
    endtask

    task automatic wait_done(input int d0, input string name);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_done_count"}, 64'(done_cnt), 64'(d0 + 1));
    endtask

    initial begin
        int d0;
        logic [9:0] exp_wrap [4];
        exp_wrap = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

        #1 rst = 1'b0;
        #1;
        chk("rst_busy_done_err", 64'({busy, done, err_zero_k}), 64'(0));
        chk("rst_rd_en", 64'({a_rd_en, b_rd_en}), 64'(0));
        chk("rst_vld", 64'({row_data_in_vld, col_data_in_vld}), 64'(0));
        chk("rst_flags", 64'({rst_accumulator_rdy, stream_out_rdy}), 64'(0));
        chk("rst_addr", 64'({a_rd_addr, b_rd_addr}), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: basic tile, full throughput
        d0 = done_cnt;
        run_tile(4, 'h10, 'h20);
        wait_done(d0, "t1");
        chk("t1_reads", 64'(rd_cnt), 64'(4));
        chk("t1_read_span", 64'(last_rd_cyc - first_rd_cyc), 64'(3));
        chk("t1_read_latency", 64'(first_rd_cyc - start_cyc), 64'(1));
        chk("t1_beat_latency", 64'(first_acc_cyc - start_cyc), 64'(3));
        chk("t1_row_beats", 64'(row_acc), 64'(4));
        chk("t1_col_beats", 64'(col_acc), 64'(4));
        chk("t1_beat_span", 64'(last_acc_cyc - first_acc_cyc), 64'(3));
        chk("t1_done_timing", 64'(done_cyc - last_acc_cyc), 64'(1));
        @(negedge clk); #1;
        chk("t1_busy_after", 64'(busy), 64'(0));

        // 2: row stream stalled every other cycle
        row_tog = 1'b1;
        d0 = done_cnt;
        run_tile(8, 'h55, 'h1A0);
        wait_done(d0, "t2");
        chk("t2_row_beats", 64'(row_acc), 64'(8));
        chk("t2_col_beats", 64'(col_acc), 64'(8));
        chk("t2_done_timing", 64'(done_cyc - last_acc_cyc), 64'(1));
        row_tog = 1'b0;
        repeat (2) @(posedge clk);

        // 3: single-beat tile
        d0 = done_cnt;
        run_tile(1, 'h3, 'h7);
        wait_done(d0, "t3");
        chk("t3_row_beats", 64'(row_acc), 64'(1));
        chk("t3_col_beats", 64'(col_acc), 64'(1));
        @(negedge clk); #1;
        chk("t3_busy_after", 64'(busy), 64'(0));

        // 4: zero-length tile, then recovery
        d0 = done_cnt;
        clear_stats();
        pulse_start(0, 'h11, 'h22);
        wait_done(d0, "t4z");
        chk("t4_err_set", 64'(err_zero_k), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("t4_no_reads", 64'(rd_cnt), 64'(0));
        chk("t4_no_beats", 64'(row_acc + col_acc), 64'(0));
        d0 = done_cnt;
        run_tile(2, 'h30, 'h31);
        chk("t4_err_cleared", 64'(err_zero_k), 64'(0));
        wait_done(d0, "t4");
        chk("t4_row_beats", 64'(row_acc), 64'(2));

        // 5: address wrap and start while busy
        a_log.delete();
        d0 = done_cnt;
        run_tile(4, 'h3FE, 'h3FD);
        chk("t5_busy", 64'(busy), 64'(1));
        pulse_start(7, 'h100, 'h200);
        wait_done(d0, "t5");
        repeat (5) @(posedge clk);
        #1;
        chk("t5_single_done", 64'(done_cnt), 64'(d0 + 1));
        chk("t5_read_count", 64'(a_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < a_log.size(); i++)
            chk("t5_wrap_addr", 64'(a_log[i]), 64'(exp_wrap[i]));

        // 6: reset in the middle of a tile
        run_tile(6, 'h80, 'h90);
        begin
            int n = 0;
            while (row_acc < 2 && n < 50) begin
                @(negedge clk); #1;
                n++;
            end
        end
        chk("t6_reached_beat2", 64'(row_acc), 64'(2));
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_vld", 64'({row_data_in_vld, col_data_in_vld}), 64'(0));
        chk("t6_rst_rd_en", 64'({a_rd_en, b_rd_en}), 64'(0));
        row_q.delete(); col_q.delete(); addr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done_after_abort", 64'(done_cnt), 64'(d0));
        run_tile(3, 'h3C, 'h4C);
        wait_done(d0, "t6");
        chk("t6_row_beats", 64'(row_acc), 64'(3));
        chk("t6_col_beats", 64'(col_acc), 64'(3));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
